ram_block_master: RTL
=====================

// Module: ram_block_master
// PURPOSE
//  Bus initiator for the 8-bit single-port RAM interface (addr, data, rd, we, 1-cycle registered read).
//  Accepts block commands: WRITE streams bytes in and stores them; READ fetches bytes and streams them out.
//  Sits between a loader/monitor (e.g. serial debug front-end) and a RAM instance, sharing the RAM port with no arbitration.
// PARAMETERS
//  ADDR_WIDTH  8  RAM address width; addresses wrap modulo 2**ADDR_WIDTH
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  reset      in   1             asynchronous, active-high reset
//  cmd_valid  in   1             command offered
//  cmd_ready  out  1             command accepted when valid&ready
//  cmd_write  in   1             1 = WRITE block, 0 = READ block
//  cmd_addr   in   ADDR_WIDTH    start address
//  cmd_len    in   ADDR_WIDTH+1  byte count, 0..2**ADDR_WIDTH
//  wr_valid   in   1             write-stream byte offered
//  wr_ready   out  1             write-stream byte accepted
//  wr_data    in   8             write-stream byte
//  rd_valid   out  1             read-stream byte offered
//  rd_ready   in   1             read-stream byte consumed
//  rd_data    out  8             read-stream byte
//  busy       out  1             command in progress
//  done       out  1             one-cycle pulse at command completion
//  mem_addr   out  ADDR_WIDTH    to RAM addr
//  mem_wdata  out  8             to RAM data_in
//  mem_rd     out  1             to RAM rd
//  mem_we     out  1             to RAM we
//  mem_rdata  in   8             from RAM data_out, valid the cycle after mem_rd
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1 once released; all other outputs 0, rd_data=0, mem_addr=0.
//  States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_OUT, DONE.
//  IDLE: cmd_ready=1. On cmd_valid: latch addr into mem_addr, count=cmd_len, busy=1.
//   len=0 -> DONE; write -> WRITE; read -> RD_ISSUE.
//  WRITE: wr_ready=1. mem_we=wr_valid, mem_wdata=wr_data (combinational, same cycle).
//   On a beat: mem_addr+1 (wrap), count-1; count reaching 0 -> DONE.
//  RD_ISSUE: mem_rd=1 for exactly one cycle at mem_addr -> RD_WAIT.
//  RD_WAIT: capture mem_rdata into rd_data -> RD_OUT.
//  RD_OUT: rd_valid=1, rd_data stable until rd_ready.
//   On handshake: mem_addr+1 (wrap), count-1; count 0 -> DONE, else -> RD_ISSUE.
//  Read timing: 3 cycles/byte with rd_ready held high; first rd_valid 3 cycles after cmd accept.
//  DONE: done=1 for one cycle, busy drops with it -> IDLE (next cmd accepted the following cycle).
//  busy = 1 from the cycle after accept through the DONE cycle inclusive.
//  mem_rd and mem_we are never high together. mem_we is never high outside WRITE.
//  wr_valid outside WRITE: ignored, wr_ready=0. rd_ready outside RD_OUT: ignored.
//  Wrap: addr 0xFF +1 -> 0x00. cmd_len=256 from 0x10 covers the whole RAM once.
//  Reset mid-command: transfer is abandoned and outputs return to reset values immediately (async).
//   Bytes already written stay in RAM.
// STRUCTURE
//  Shared package mem_bus_pkg: ADDR_WIDTH default, state encodings (localparam), CMD_READ/CMD_WRITE encodings.
//  Single module: one FSM plus address and count registers. No sub-module needed.
// TESTING (bench pairs the block with a ram_memory model)
//  WRITE addr=0x20 len=4, bytes A1 A2 A3 A4 with wr_valid gaps
//   -> RAM[0x20..0x23]=A1..A4; done pulses once; busy low after.
//  READ addr=0x20 len=4, rd_ready=1
//   -> rd_data A1,A2,A3,A4; rd_valid 3 cycles after accept, then every 3 cycles.
//  READ len=2 with rd_ready low for 5 cycles on byte 0
//   -> rd_data held stable; mem_rd not reasserted until the handshake.
//  WRITE addr=0xFE len=3 (01 02 03)
//   -> RAM[0xFE]=01, [0xFF]=02, [0x00]=03 (wrap).
//  cmd_len=0
//   -> no mem_rd/mem_we; done 1 cycle after accept; cmd_ready back next cycle.
//  reset asserted mid-READ len=8 after byte 2
//   -> all outputs 0 in same cycle; IDLE after release; new READ works.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings for the 8-bit single-port RAM bus master
package mem_bus_pkg;

  localparam int ADDR_WIDTH_DEF = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_OUT   = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  // First state after accepting a non-empty command.
  function automatic state_e first_state(input logic cmd_write);
    state_e st;
    st = S_RD_ISSUE;
    case (cmd_write)
      CMD_WRITE: st = S_WRITE;
      CMD_READ:  st = S_RD_ISSUE;
      default:   st = S_RD_ISSUE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ram_block_master.sv
// rtl/ram_block_master.sv - block read/write initiator for a single-port RAM with 1-cycle registered read
module ram_block_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata
);

  localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [7:0]            rdata_q, rdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          count_d = cmd_len;
          state_d = (cmd_len == '0) ? S_DONE : first_state(cmd_write);
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          count_d = count_q - LAST_BEAT;
          if (count_q == LAST_BEAT) state_d = S_DONE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rdata_d = mem_rdata;
        state_d = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (rd_ready) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          count_d = count_q - LAST_BEAT;
          state_d = (count_q == LAST_BEAT) ? S_DONE : S_RD_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cmd_ready is masked by reset so every output reads 0 while reset is held.
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign wr_ready  = (state_q == S_WRITE);
  assign mem_we    = (state_q == S_WRITE) && wr_valid;
  assign mem_wdata = (state_q == S_WRITE) ? wr_data : 8'h00;
  assign mem_rd    = (state_q == S_RD_ISSUE);
  assign rd_valid  = (state_q == S_RD_OUT);
  assign rd_data   = rdata_q;
  assign mem_addr  = addr_q;

endmodule
